// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions
// and the hex glyph table (bit0 = a ... bit6 = g, active-high).
package seg_pkg;

  // Segment bit positions inside a 7-bit glyph
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_glyph_t;
  typedef logic [3:0]       seg_nibble_t;

  // Hex glyphs 0..F
  localparam seg_glyph_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Table lookup wrapped as a function so callers need not know the layout
  function automatic seg_glyph_t seg_glyph(input seg_nibble_t nib);
    return SEG_GLYPH[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble -> seven-segment glyph decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_W-1:0] o_seg
);

  // Pure table lookup; no state
  always_comb begin
    o_seg = seg_glyph(i_nib);
  end

endmodule

// File: rtl/seg_scanner.sv
// Multiplexed common-cathode seven-segment driver. One digit is shown per
// scan slot; data is double-buffered (staging -> active) and only swapped
// at frame boundaries so a frame never mixes old and new digits.
module seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIV_W   = 10,
  parameter int BLINK_W = 6,
  parameter int DIM_W   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   blink_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic [DIM_W-1:0]    brightness,
  output logic                ack,
  output logic [SEG_W-1:0]    seg,
  output logic [DIGITS-1:0]   an
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Scan timing state
  logic [DIV_W-1:0]    r_pres;
  logic [IDX_W-1:0]    r_idx;
  logic [BLINK_W-1:0]  r_blink_cnt;

  // Staging (written by load) and active (feeds the display) buffers
  logic [4*DIGITS-1:0] r_stg_dig;
  logic [DIGITS-1:0]   r_stg_blink;
  logic [DIGITS-1:0]   r_stg_blank;
  logic [4*DIGITS-1:0] r_act_dig;
  logic [DIGITS-1:0]   r_act_blink;
  logic [DIGITS-1:0]   r_act_blank;
  logic                r_pending;

  // Output registers
  logic                r_ack;
  logic [SEG_W-1:0]    r_seg;
  logic [DIGITS-1:0]   r_an;

  // Combinational helpers
  logic                w_tick;
  logic                w_fb;
  logic                w_apply;
  logic                w_phase;
  logic [DIM_W-1:0]    w_duty;
  logic                w_dim_on;
  logic                w_blank_sel;
  logic                w_blink_sel;
  logic                w_lit;
  logic [3:0]          w_nib;
  logic [3:0]          w_nib_arr [DIGITS];
  logic [SEG_W-1:0]    w_glyph;
  logic [SEG_W-1:0]    w_seg_next;
  logic [DIGITS-1:0]   w_an_next;

  assign w_tick   = &r_pres;
  assign w_fb     = w_tick & (r_idx == IDX_LAST);
  assign w_apply  = w_fb & r_pending;
  // Blink phase 0 (first half of the blink period) is the dark half
  assign w_phase  = r_blink_cnt[BLINK_W-1];
  // Top prescaler bits act as a PWM ramp compared against the duty level
  assign w_duty   = r_pres[DIV_W-1 -: DIM_W];
  assign w_dim_on = (w_duty <= brightness);

  // Split the active digit word into one nibble per digit
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_nib_arr[gi] = r_act_dig[4*gi +: 4];
    end
  endgenerate

  assign w_nib       = w_nib_arr[r_idx];
  assign w_blank_sel = r_act_blank[r_idx];
  assign w_blink_sel = r_act_blink[r_idx];

  // Blank beats blink; blink only darkens during phase 0
  assign w_lit = ~w_blank_sel & ~(w_blink_sel & ~w_phase) & w_dim_on;

  seg_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  assign w_seg_next = w_lit ? w_glyph : '0;

  // One-hot anode for the current slot, forced dark when not lit
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
      assign w_an_next[gi] = w_lit & (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Free-running slot prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pres <= '0;
    end else begin
      r_pres <= r_pres + DIV_W'(1);
    end
  end

  // Digit index: advance once per slot, wrap after the last digit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Blink counter counts slots and wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
    end else if (w_tick) begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // Staging buffer: last load wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_dig   <= '0;
      r_stg_blink <= '0;
      r_stg_blank <= '0;
    end else if (load) begin
      r_stg_dig   <= digits_in;
      r_stg_blink <= blink_in;
      r_stg_blank <= blank_in;
    end
  end

  // Pending flag: a load during the frame-boundary cycle keeps it set
  // so the newer data is applied one frame later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= load | (r_pending & ~w_fb);
    end
  end

  // Active buffer swaps only on a frame boundary, taking pre-edge staging
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_dig   <= '0;
      r_act_blink <= '0;
      r_act_blank <= '0;
    end else if (w_apply) begin
      r_act_dig   <= r_stg_dig;
      r_act_blink <= r_stg_blink;
      r_act_blank <= r_stg_blank;
    end
  end

  // Registered outputs: one cycle behind the scan state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
      r_seg <= '0;
      r_an  <= '0;
    end else begin
      r_ack <= w_apply;
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign ack = r_ack;
  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg_scanner.sv
// Directed bench for seg_scanner (DIGITS=4, DIV_W=4, BLINK_W=2, DIM_W=2).
// A cycle-count based reference model predicts seg/an/ack every cycle;
// literal checks pin scan order, glyphs, ack timing, blink and duty.
module tb_seg_scanner;

  localparam int DIGITS  = 4;
  localparam int DIV_W   = 4;
  localparam int BLINK_W = 2;
  localparam int DIM_W   = 2;
  localparam int SLOT    = 16;          // clk cycles per slot
  localparam int FRAME   = 64;          // clk cycles per frame
  localparam int DUTY_STEP = 4;         // 2^(DIV_W-DIM_W)

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blink_in = '0;
  logic [3:0]  blank_in = '0;
  logic [1:0]  brightness = 2'd3;
  logic        ack;
  logic [6:0]  seg;
  logic [3:0]  an;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 1'b0;
  int cnt_an [4];
  int ack_cnt = 0;

  logic [6:0] glyph_tab [16];

  // Reference model state
  int unsigned m_t = 0;                 // edges since reset release
  logic [15:0] m_stg_dig = '0, m_act_dig = '0;
  logic [3:0]  m_stg_blink = '0, m_act_blink = '0;
  logic [3:0]  m_stg_blank = '0, m_act_blank = '0;
  bit          m_pend = 1'b0;
  logic [6:0]  e_seg = '0;
  logic [3:0]  e_an = '0;
  logic        e_ack = 1'b0;

  seg_scanner #(
    .DIGITS  (DIGITS),
    .DIV_W   (DIV_W),
    .BLINK_W (BLINK_W),
    .DIM_W   (DIM_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .digits_in  (digits_in),
    .blink_in   (blink_in),
    .blank_in   (blank_in),
    .brightness (brightness),
    .ack        (ack),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  // Model: derive slot position, digit and blink phase from the cycle count
  always @(posedge clk or negedge reset_n) begin : model
    int slot, pos, dig;
    bit phase, fb, lit;
    if (!reset_n) begin
      m_t         <= 0;
      m_stg_dig   <= '0; m_act_dig   <= '0;
      m_stg_blink <= '0; m_act_blink <= '0;
      m_stg_blank <= '0; m_act_blank <= '0;
      m_pend      <= 1'b0;
      e_seg <= '0; e_an <= '0; e_ack <= 1'b0;
    end else begin
      pos   = int'(m_t % SLOT);
      slot  = int'(m_t / SLOT);
      dig   = slot % DIGITS;
      phase = (slot % 4) >= 2;           // blink period is 4 slots, dark half first
      fb    = (m_t % FRAME) == FRAME - 1;
      lit   = !m_act_blank[dig] && !(m_act_blink[dig] && !phase) &&
              ((pos / DUTY_STEP) <= int'(brightness));
      e_ack <= fb && m_pend;
      e_seg <= lit ? glyph_tab[m_act_dig[4*dig +: 4]] : 7'h00;
      e_an  <= lit ? 4'(1 << dig) : 4'b0000;
      if (fb && m_pend) begin
        m_act_dig   <= m_stg_dig;
        m_act_blink <= m_stg_blink;
        m_act_blank <= m_stg_blank;
      end
      if (load) begin
        m_stg_dig   <= digits_in;
        m_stg_blink <= blink_in;
        m_stg_blank <= blank_in;
      end
      m_pend <= load || (m_pend && !fb);
      m_t    <= m_t + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n cycles; each falling edge compares DUT against the model
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (chk_en) begin
        vec_cnt++;
        if ({seg, an, ack} !== {e_seg, e_an, e_ack}) begin
          err_cnt++;
          $display("FAIL model t=%0t: got seg=%h an=%b ack=%b, want seg=%h an=%b ack=%b",
                   $time, seg, an, ack, e_seg, e_an, e_ack);
        end
      end
      for (int d = 0; d < 4; d++) cnt_an[d] += int'(an[d]);
      if (ack) ack_cnt++;
      #1;
    end
  endtask

  task automatic clr_cnt();
    for (int d = 0; d < 4; d++) cnt_an[d] = 0;
  endtask

  task automatic scan_order(input string tag);
    step(1);
    chk({tag, " an slot0"}, an, 4'b0001);
    chk({tag, " seg slot0"}, seg, 7'h3F);
    chk({tag, " ack slot0"}, ack, 0);
    step(16);
    chk({tag, " an slot1"}, an, 4'b0010);
    step(16);
    chk({tag, " an slot2"}, an, 4'b0100);
    step(16);
    chk({tag, " an slot3"}, an, 4'b1000);
    chk({tag, " seg slot3"}, seg, 7'h3F);
  endtask

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    clr_cnt();

    // Reset and free-running scan with default data
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    step(3);
    chk("reset seg", seg, 0);
    chk("reset an", an, 0);
    reset_n = 1'b1;
    scan_order("scan");                         // now just after edge 48

    // Mid-frame load of A981
    load = 1'b1; digits_in = 16'hA981; ack_cnt = 0;
    step(1);                                    // edge 49
    load = 1'b0; digits_in = 16'hFFFF;
    step(14);                                   // edge 63: fb registered
    chk("ack after fb", ack, 1);
    chk("old data holds", seg, 7'h3F);
    step(1);                                    // edge 64
    chk("new d0 seg", seg, 7'h06);
    chk("new d0 an", an, 4'b0001);
    chk("ack one cycle", ack, 0);
    step(16);
    chk("new d1 seg", seg, 7'h7F);
    step(16);
    chk("new d2 seg", seg, 7'h6F);
    step(16);                                   // edge 112
    chk("new d3 seg", seg, 7'h77);
    chk("ack count", ack_cnt, 1);

    // Load coinciding with fb while another load is pending
    load = 1'b1; digits_in = 16'h1234;
    step(1);                                    // edge 113
    load = 1'b0;
    step(13);                                   // edge 126
    load = 1'b1; digits_in = 16'h5678;
    step(1);                                    // edge 127 = fb
    load = 1'b0; digits_in = 16'h0000;
    chk("fb-load old acked", ack, 1);
    step(1);                                    // edge 128
    chk("fb-load old shown", seg, 7'h66);
    step(63);                                   // edge 191 = next fb
    chk("fb-load new acked", ack, 1);
    step(1);                                    // edge 192
    chk("fb-load new shown", seg, 7'h7F);

    // Blink on digit 2, blank on digit 0
    load = 1'b1; digits_in = 16'h5678; blink_in = 4'b0100; blank_in = 4'b0001;
    step(1);                                    // edge 193
    load = 1'b0; blink_in = 4'b0000; blank_in = 4'b0000;
    step(62);                                   // edge 255: new masks live next
    clr_cnt();
    step(256);                                  // edges 256..511
    chk("blank d0 lit cycles", cnt_an[0], 0);
    chk("plain d1 lit cycles", cnt_an[1], 64);
    chk("blink d2 lit cycles", cnt_an[2], 64);
    chk("plain d3 lit cycles", cnt_an[3], 64);

    // Brightness extremes over one full frame
    brightness = 2'd0; clr_cnt();
    step(64);
    chk("dim0 d3 duty", cnt_an[3], 4);
    chk("dim0 d1 duty", cnt_an[1], 4);
    brightness = 2'd3; clr_cnt();
    step(64);                                   // edge 639
    chk("dim3 d3 duty", cnt_an[3], 16);
    chk("dim3 d2 duty", cnt_an[2], 16);

    // Asynchronous reset mid-slot while a digit is lit
    step(20);                                   // edge 659: digit 1 slot
    chk("pre-reset an", an, 4'b0010);
    chk("pre-reset seg", seg, 7'h07);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset seg", seg, 0);
    chk("async reset an", an, 0);
    chk("async reset ack", ack, 0);
    step(3);
    reset_n = 1'b1;
    scan_order("rescan");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
